// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch queue:
//   - default address / instruction widths and PC step
//   - fetch_entry_t : one buffered instruction together with its PC
//   - pc_increment  : PC advance helper, evaluated at a wide width so callers
//                     of any ADDR_WIDTH (up to 64) truncate to get the wrap
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_ADDR_WIDTH  = 32;
  localparam int FETCH_INSTR_WIDTH = 32;
  localparam int FETCH_INSTR_BYTES = 4;
  localparam int PC_MAX_WIDTH      = 64;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0]  pc;
    logic [FETCH_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Callers cast the result back to their own width; the discarded high
  // bits give the modulo-2^ADDR_WIDTH wrap for free.
  function automatic logic [PC_MAX_WIDTH-1:0] pc_increment(
    input logic [PC_MAX_WIDTH-1:0] pc,
    input int unsigned             step
  );
    return pc + PC_MAX_WIDTH'(step);
  endfunction

endpackage

// File: rtl/fetch_entry_fifo.sv
// ---------------------------------------------------------------------------
// fetch_entry_fifo
// DEPTH-entry synchronous FIFO of fetched instructions. Pointers wrap
// modulo DEPTH, so non-power-of-two depths work. The head entry is read
// straight from the storage array, so it is a function of registered state
// only and stays stable until it is popped.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (empties the FIFO)
//   flush    in   empties the FIFO; wins over wr_en / rd_en
//   wr_en    in   push wr_data (caller guarantees space, or a same-cycle pop)
//   wr_data  in   entry to push
//   rd_en    in   pop the head (caller guarantees count > 0)
//   rd_data  out  head entry
//   count    out  number of valid entries
// ---------------------------------------------------------------------------
module fetch_entry_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  entry_t                     wr_data,
  input  logic                       rd_en,
  output entry_t                     rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  function automatic logic [PTR_W-1:0] ptr_advance(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Storage needs no reset: an entry is only read once count covers it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= ptr_advance(wr_ptr_reg);
      end
      if (rd_en) begin
        rd_ptr_reg <= ptr_advance(rd_ptr_reg);
      end
      // A simultaneous push and pop leaves the count unchanged, even when full.
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/instruction_fetch_queue.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue
// Generates sequential PCs, issues pipelined in-order requests to the
// instruction cache and buffers the returned instructions for decode.
// A request is only issued if a queue slot is reserved for its response,
// so the queue can never overflow. A redirect flushes the queue, restarts
// fetch at the aligned target and drops every response still in flight.
//
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   redirect_valid / redirect_pc           branch/exception redirect
//   icache_req_valid/_addr/_ready          request channel to the cache
//   icache_resp_valid / icache_resp_instr  in-order responses, no back-pressure
//   deq_valid/_instr/_pc/_ready            head of queue to decode
//   occupancy                              valid entries in the queue
// ---------------------------------------------------------------------------
module instruction_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = FETCH_ADDR_WIDTH,
  parameter int                    INSTR_WIDTH     = FETCH_INSTR_WIDTH,
  parameter int                    INSTR_BYTES     = FETCH_INSTR_BYTES,
  parameter int                    DEPTH           = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [ADDR_WIDTH-1:0]      redirect_pc,
  output logic                       icache_req_valid,
  output logic [ADDR_WIDTH-1:0]      icache_req_addr,
  input  logic                       icache_req_ready,
  input  logic                       icache_resp_valid,
  input  logic [INSTR_WIDTH-1:0]     icache_resp_instr,
  output logic                       deq_valid,
  output logic [INSTR_WIDTH-1:0]     deq_instr,
  output logic [ADDR_WIDTH-1:0]      deq_pc,
  input  logic                       deq_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INSTR_BYTES-1);

  // Entry type sized by this instance's widths (the package type carries
  // the default widths only).
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc_reg,    fetch_pc_next;
  logic [ADDR_WIDTH-1:0] resp_pc_reg,     resp_pc_next;
  logic [CNT_W-1:0]      outstanding_reg, outstanding_next;
  logic [CNT_W-1:0]      discard_cnt_reg, discard_cnt_next;
  logic [CNT_W-1:0]      count;
  logic [CNT_W:0]        credit_used;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  req_fire;
  logic                  deq_fire;
  logic                  resp_keep;
  entry_t                enq_entry;
  entry_t                head_entry;

  function automatic logic [ADDR_WIDTH-1:0] pc_step(input logic [ADDR_WIDTH-1:0] pc);
    return ADDR_WIDTH'(pc_increment(PC_MAX_WIDTH'(pc), INSTR_BYTES));
  endfunction

  // Queue entries plus in-flight requests: each in-flight request owns a slot.
  assign credit_used = {1'b0, count} + {1'b0, outstanding_reg};

  // Never looks at icache_req_ready, so there is no combinational loop
  // through the cache.
  assign icache_req_valid = !rst && !redirect_valid
                            && (outstanding_reg < CNT_W'(MAX_OUTSTANDING))
                            && (credit_used < (CNT_W+1)'(DEPTH));
  assign icache_req_addr  = fetch_pc_reg;
  assign req_fire         = icache_req_valid && icache_req_ready;

  assign deq_valid = !rst && (count != '0);
  assign deq_fire  = deq_valid && deq_ready;
  assign deq_pc    = head_entry.pc;
  assign deq_instr = head_entry.instr;
  assign occupancy = rst ? '0 : count;

  // Responses in the redirect cycle, or still owed to a pre-redirect
  // stream, are dropped on the floor.
  assign resp_keep       = !rst && icache_resp_valid && !redirect_valid
                           && (discard_cnt_reg == '0);
  assign redirect_target = redirect_pc & ALIGN_MASK;
  assign enq_entry       = '{pc: resp_pc_reg, instr: icache_resp_instr};

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    discard_cnt_next = discard_cnt_reg;
    // Responses keep draining the in-flight count even across a redirect.
    outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(icache_resp_valid);
    if (redirect_valid) begin
      fetch_pc_next    = redirect_target;
      resp_pc_next     = redirect_target;
      // Everything in flight after this cycle belongs to the old stream.
      discard_cnt_next = outstanding_reg - CNT_W'(icache_resp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_next = pc_step(fetch_pc_reg);
      end
      if (icache_resp_valid) begin
        if (discard_cnt_reg != '0) begin
          discard_cnt_next = discard_cnt_reg - CNT_W'(1);
        end else begin
          resp_pc_next = pc_step(resp_pc_reg);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      discard_cnt_reg <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_cnt_reg <= discard_cnt_next;
    end
  end

  fetch_entry_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .wr_en   (resp_keep),
    .wr_data (enq_entry),
    .rd_en   (deq_fire),
    .rd_data (head_entry),
    .count   (count)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(icache_resp_valid && (outstanding_reg == '0)))
        else $error("icache response with no request in flight");
      assert (credit_used <= (CNT_W+1)'(DEPTH))
        else $error("queued plus in-flight entries exceed DEPTH");
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int IB    = 4;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [AW-1:0] RESET_PC = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          icache_req_valid;
  logic [AW-1:0] icache_req_addr;
  logic          icache_req_ready = 1'b0;
  logic          icache_resp_valid = 1'b0;
  logic [IW-1:0] icache_resp_instr = '0;
  logic          deq_valid;
  logic [IW-1:0] deq_instr;
  logic [AW-1:0] deq_pc;
  logic          deq_ready = 1'b0;
  logic [CW-1:0] occupancy;

  always #5 clk = ~clk;

  instruction_fetch_queue #(
    .ADDR_WIDTH      (AW),
    .INSTR_WIDTH     (IW),
    .INSTR_BYTES     (IB),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .icache_req_valid  (icache_req_valid),
    .icache_req_addr   (icache_req_addr),
    .icache_req_ready  (icache_req_ready),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_instr (icache_resp_instr),
    .deq_valid         (deq_valid),
    .deq_instr         (deq_instr),
    .deq_pc            (deq_pc),
    .deq_ready         (deq_ready),
    .occupancy         (occupancy)
  );

  // Reference model: the cache's list of requests it still owes (each
  // tagged stale once a redirect has happened) and a plain queue of the
  // instructions decode should see, in order.
  typedef struct {
    logic [AW-1:0] addr;
    int unsigned   issued;
    bit            stale;
  } flight_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } ref_entry_t;

  flight_t     inflight[$];
  ref_entry_t  ref_q[$];
  logic [AW-1:0] m_fetch_pc = RESET_PC;
  int unsigned cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  // Pre-edge samples of the DUT from the most recent step.
  logic          s_req_valid, s_req_fire, s_deq_valid, s_deq_fire;
  logic [AW-1:0] s_req_addr, s_deq_pc;
  logic [IW-1:0] s_deq_instr;
  logic [CW-1:0] s_occ;

  function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample and check
  // against the model, then advance the model across the rising edge.
  task automatic step(input bit r, input bit rv, input logic [AW-1:0] rpc,
                      input bit rdy, input bit ren, input bit dr);
    bit         resp, exp_req, exp_deq;
    flight_t    f;
    ref_entry_t e;
    @(negedge clk);
    rst              = r;
    redirect_valid   = rv;
    redirect_pc      = rpc;
    icache_req_ready = rdy;
    deq_ready        = dr;
    resp = !r && ren && (inflight.size() > 0) && (inflight[0].issued < cyc);
    icache_resp_valid = resp;
    icache_resp_instr = resp ? instr_of(inflight[0].addr) : IW'($urandom);
    #1;
    s_req_valid = icache_req_valid;
    s_req_addr  = icache_req_addr;
    s_req_fire  = icache_req_valid & icache_req_ready;
    s_deq_valid = deq_valid;
    s_deq_pc    = deq_pc;
    s_deq_instr = deq_instr;
    s_deq_fire  = deq_valid & deq_ready;
    s_occ       = occupancy;

    exp_req = !r && !rv && (inflight.size() < MAXO)
              && (ref_q.size() + inflight.size() < DEPTH);
    exp_deq = !r && (ref_q.size() > 0);
    check("model_req_valid", s_req_valid, exp_req);
    if (exp_req) check("model_req_addr", s_req_addr, m_fetch_pc);
    check("model_deq_valid", s_deq_valid, exp_deq);
    if (exp_deq) begin
      check("model_deq_pc", s_deq_pc, ref_q[0].pc);
      check("model_deq_instr", s_deq_instr, ref_q[0].instr);
    end
    check("model_occupancy", s_occ, r ? 0 : ref_q.size());

    @(posedge clk);
    if (r) begin
      inflight.delete();
      ref_q.delete();
      m_fetch_pc = RESET_PC;
    end else begin
      if (exp_deq && dr) void'(ref_q.pop_front());
      if (resp) begin
        f = inflight.pop_front();
        if (!f.stale && !rv) begin
          e.pc = f.addr;
          e.instr = instr_of(f.addr);
          ref_q.push_back(e);
        end
      end
      if (rv) begin
        ref_q.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        m_fetch_pc = rpc & ~AW'(IB-1);
      end else if (exp_req && rdy) begin
        f.addr = m_fetch_pc;
        f.issued = cyc;
        f.stale = 1'b0;
        inflight.push_back(f);
        m_fetch_pc = m_fetch_pc + AW'(IB);
      end
    end
    cyc++;
  endtask

  typedef struct {
    bit          rst;
    bit          deq_ready;
    bit          exp_req_valid;
    logic [31:0] exp_req_addr;
    bit          exp_deq_valid;
    logic [31:0] exp_deq_pc;
    int          exp_occ;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int          got;
    int          nreq;
    int          ndeq;
    logic [AW-1:0] wrap_exp;

    // Back-pressure fill: ready cache answering one cycle later, decode
    // stalled, then one cycle of deq_ready.
    vecs[0]  = '{1, 0, 0, 32'h0,  0, 32'h0, 0};
    vecs[1]  = '{0, 0, 1, 32'h0,  0, 32'h0, 0};
    vecs[2]  = '{0, 0, 1, 32'h4,  0, 32'h0, 0};
    vecs[3]  = '{0, 0, 1, 32'h8,  1, 32'h0, 1};
    vecs[4]  = '{0, 0, 1, 32'hC,  1, 32'h0, 2};
    vecs[5]  = '{0, 0, 0, 32'h0,  1, 32'h0, 3};
    vecs[6]  = '{0, 0, 0, 32'h0,  1, 32'h0, 4};
    vecs[7]  = '{0, 1, 0, 32'h0,  1, 32'h0, 4};
    vecs[8]  = '{0, 0, 1, 32'h10, 1, 32'h4, 3};
    vecs[9]  = '{0, 0, 0, 32'h0,  1, 32'h4, 3};
    vecs[10] = '{0, 0, 0, 32'h0,  1, 32'h4, 4};
    vecs[11] = '{0, 0, 0, 32'h0,  1, 32'h4, 4};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rst, 0, '0, 1, 1, vecs[i].deq_ready);
      $display("vec %0d: req_valid=%0b addr=0x%0h deq_valid=%0b deq_pc=0x%0h occupancy=%0d",
               i, s_req_valid, s_req_addr, s_deq_valid, s_deq_pc, s_occ);
      check($sformatf("vec%0d_req_valid", i), s_req_valid, vecs[i].exp_req_valid);
      if (vecs[i].exp_req_valid)
        check($sformatf("vec%0d_req_addr", i), s_req_addr, vecs[i].exp_req_addr);
      check($sformatf("vec%0d_deq_valid", i), s_deq_valid, vecs[i].exp_deq_valid);
      if (vecs[i].exp_deq_valid)
        check($sformatf("vec%0d_deq_pc", i), s_deq_pc, vecs[i].exp_deq_pc);
      check($sformatf("vec%0d_occupancy", i), s_occ, vecs[i].exp_occ);
    end

    // Streaming: one request and one dequeue per cycle at steady state.
    step(1, 0, '0, 1, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, '0, 1, 1, 1);
      check("stream_req_valid", s_req_valid, 1);
      check("stream_req_addr", s_req_addr, 4 * (i - 1));
      if (i >= 3) begin
        check("stream_deq_valid", s_deq_valid, 1);
        check("stream_deq_pc", s_deq_pc, 4 * (i - 3));
      end
    end
    $display("stream: 8 cycles of in-order fetch and dequeue");

    // Redirect while 0x10 and 0x14 are in flight, with 0x10 returning in
    // the redirect cycle; target 0x103 aligns to 0x100.
    step(1, 0, '0, 1, 0, 1);
    step(0, 1, 32'h10, 1, 0, 1);
    step(0, 0, '0, 1, 0, 1);
    check("redir_req_addr_0x10", s_req_addr, 32'h10);
    step(0, 0, '0, 1, 0, 1);
    check("redir_req_addr_0x14", s_req_addr, 32'h14);
    step(0, 1, 32'h103, 1, 1, 1);
    check("redir_no_req_in_redirect_cycle", s_req_valid, 0);
    step(0, 0, '0, 1, 1, 1);
    check("redir_next_req_valid", s_req_valid, 1);
    check("redir_next_req_addr", s_req_addr, 32'h100);
    step(0, 0, '0, 1, 1, 1);
    check("redir_stale_dropped_occ", s_occ, 0);
    step(0, 0, '0, 1, 1, 1);
    check("redir_first_deq_valid", s_deq_valid, 1);
    check("redir_first_deq_pc", s_deq_pc, 32'h100);
    $display("redirect: 0x103 with two requests in flight");

    // Back-to-back redirects with responses still pending.
    step(0, 0, '0, 1, 1, 1);
    step(0, 1, 32'h200, 1, 1, 1);
    step(0, 1, 32'h300, 1, 1, 1);
    got = 0;
    for (int i = 0; i < 30 && got < 4; i++) begin
      step(0, 0, '0, 1, 1, 1);
      if (s_deq_fire) begin
        check("redir2_deq_pc", s_deq_pc, 32'h300 + 4 * got);
        got++;
      end
    end
    check("redir2_deq_seen", got, 4);
    $display("double redirect: 0x200 then 0x300");

    // PC wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFFC, 1, 1, 1);
    nreq = 0;
    ndeq = 0;
    for (int i = 0; i < 30 && (nreq < 2 || ndeq < 2); i++) begin
      step(0, 0, '0, 1, 1, 1);
      if (s_req_fire && nreq < 2) begin
        wrap_exp = 32'hFFFF_FFFC + AW'(4 * nreq);
        check("wrap_req_addr", s_req_addr, wrap_exp);
        nreq++;
      end
      if (s_deq_fire && ndeq < 2) begin
        wrap_exp = 32'hFFFF_FFFC + AW'(4 * ndeq);
        check("wrap_deq_pc", s_deq_pc, wrap_exp);
        ndeq++;
      end
    end
    check("wrap_req_seen", nreq, 2);
    check("wrap_deq_seen", ndeq, 2);
    $display("wrap: 0xFFFFFFFC -> 0x00000000");

    // Reset with entries queued and both credits in flight.
    step(1, 0, '0, 1, 0, 0);
    step(0, 0, '0, 1, 0, 0);
    step(0, 0, '0, 1, 0, 0);
    step(0, 0, '0, 1, 1, 0);
    step(0, 0, '0, 1, 1, 0);
    step(0, 0, '0, 1, 0, 0);
    step(0, 0, '0, 1, 0, 0);
    check("rstmid_occ_before", s_occ, 2);
    check("rstmid_credit_full", s_req_valid, 0);
    step(1, 0, '0, 1, 0, 0);
    check("rstmid_occ_during", s_occ, 0);
    check("rstmid_deq_valid_during", s_deq_valid, 0);
    check("rstmid_req_valid_during", s_req_valid, 0);
    step(0, 0, '0, 1, 1, 1);
    check("rstmid_occ_after", s_occ, 0);
    check("rstmid_deq_valid_after", s_deq_valid, 0);
    check("rstmid_req_valid_after", s_req_valid, 1);
    check("rstmid_req_addr_after", s_req_addr, RESET_PC);
    $display("mid-operation reset with queued and in-flight entries");

    // Random traffic against the model.
    step(1, 0, '0, 1, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 19) == 0,
           AW'($urandom),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 2) != 0);
    end
    $display("random: 3000 cycles against the reference model");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
